// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port of mem_port_arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Requester 0: core fetch/load/store path
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_done;
  // Requester 1: loader / debug / DMA
  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_done;
  // Shared results and memory side
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;
  logic          err;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata, mem_ready,
    output m0_gnt, m0_done, m1_gnt, m1_done,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata, mem_ready,
    input  m0_gnt, m0_done, m1_gnt, m1_done,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters.
// A request is latched in IDLE, the bus is held in ACCESS until mem_ready,
// then the arbiter returns to IDLE and re-arbitrates in the done cycle.
// Optional access timeout: define ARB_TIMEOUT_EN to abort an ACCESS after
// TIMEOUT cycles without mem_ready (done + err pulse together).
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic {StIdle, StAccess} state_e;

  state_e        r_state;
  state_e        w_state_next;

  logic          r_owner;       // 0: m0, 1: m1
  logic          r_last_owner;  // owner of the last finished access
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_gnt;
  logic [1:0]    r_done;

  logic          w_access;
  logic          w_any_req;
  logic          w_sel;
  logic          w_start;
  logic          w_complete;
  logic          w_abort;
  logic          w_timeout;

  assign w_access = (r_state == StAccess);

  // Pick a requester: a lone request wins, a tie goes to the non-last owner
  always_comb begin
    w_any_req = bus.m0_req | bus.m1_req;
    w_sel     = (bus.m0_req & bus.m1_req) ? ~r_last_owner : bus.m1_req;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_complete   = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_start      = 1'b1;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        // mem_ready takes priority over a coinciding timeout
        if (bus.mem_ready) begin
          w_complete   = 1'b1;
          w_state_next = StIdle;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latched request, read data and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_sel;
        r_we    <= w_sel ? bus.m1_we    : bus.m0_we;
        r_addr  <= w_sel ? bus.m1_addr  : bus.m0_addr;
        r_wdata <= w_sel ? bus.m1_wdata : bus.m0_wdata;
      end
      if (w_complete && !r_we) begin
        r_rdata <= bus.mem_rdata;
      end
      if (w_complete || w_abort) begin
        r_last_owner <= r_owner;
      end
    end
  end

  // One-cycle gnt/done pulses, registered so they follow the state edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt  <= 2'b00;
      r_done <= 2'b00;
    end else begin
      r_gnt  <= w_start ? (w_sel ? 2'b10 : 2'b01) : 2'b00;
      r_done <= (w_complete || w_abort) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_err;

  assign w_timeout = (r_cnt == CntW'(TIMEOUT - 1));

  // Count ACCESS cycles that pass without mem_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_access && !bus.mem_ready && !w_timeout) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      r_err <= w_abort;
    end
  end

  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif

  assign bus.mem_en    = w_access;
  assign bus.busy      = w_access;
  assign bus.mem_we    = r_we & w_access;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.m0_gnt    = r_gnt[0];
  assign bus.m1_gnt    = r_gnt[1];
  assign bus.m0_done   = r_done[0];
  assign bus.m1_done   = r_done[1];

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between two requesters.
  - m0: multicycle core fetch/load/store path.
  - m1: secondary master (program loader / debug / DMA).
- Round-robin FSM. Latches one request, holds the memory bus until mem_ready, returns read data, then re-arbitrates.
- Sits between the core datapath's address mux and the memory block.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 16: max ACCESS cycles before abort. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- m0_req  input  1  m0 access request; held until m0_gnt
- m0_we  input  1  m0 write enable (0 = read)
- m0_addr  input  AW  m0 address
- m0_wdata  input  DW  m0 write data
- m0_gnt  output  1  one-cycle pulse: m0 request latched
- m0_done  output  1  one-cycle pulse: m0 access complete
- m1_req, m1_we, m1_addr, m1_wdata  input  1/1/AW/DW  same as m0 for m1
- m1_gnt, m1_done  output  1/1  same as m0 for m1
- rdata  output  DW  read data of the last completed read; held
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  AW  latched address
- mem_wdata  output  DW  latched write data
- mem_rdata  input  DW  memory read data
- mem_ready  input  1  memory completes the current access this cycle
- busy  output  1  high while in ACCESS
- err  output  1  one-cycle pulse on timeout abort (0 when macro is off)

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - All outputs 0, including rdata, mem_addr and mem_wdata.
  - last_owner = 1, so m0 wins the first tie.
- Reset asserted mid-ACCESS abandons the access. No done or err is issued.
- IDLE:
  - No req: stay in IDLE; mem_en = 0.
  - One req: select that master.
  - Both req: select the master that is not last_owner.
  - On the next edge: latch addr/we/wdata into the mem_* registers, set owner, state = ACCESS.
- ACCESS, first cycle:
  - owner's gnt = 1 for exactly this cycle.
  - mem_en = 1 and busy = 1 for every ACCESS cycle.
  - mem_we/mem_addr/mem_wdata stay constant for the whole access.
- ACCESS, mem_ready sampled high at an edge:
  - If a read: rdata <= mem_rdata.
  - Owner's done = 1 in the following cycle, for one cycle only.
  - last_owner <= owner; state = IDLE.
- Writes pulse done but leave rdata unchanged.
- done cycle coincides with IDLE, so a new arbitration happens in that same cycle.
  - Zero-wait memory gives one access every 2 cycles.
  - Continuous requests from both masters strictly alternate m0, m1, m0, ...
- mem_ready while in IDLE is ignored.
- req dropped before gnt: no access occurs and no state change.
- After gnt, a requester may change or drop its inputs; the latched copy is used.
- Only one of m0_gnt/m1_gnt/m0_done/m1_done may be high per cycle per master. gnt and done are never both high for the same master in the same cycle.
- Memory side sees no combinational path from m*_req to mem_*. All mem_* outputs are registered or decoded from the state register.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready.
  - When the count reaches TIMEOUT-1 with no mem_ready: state = IDLE and mem_en drops.
  - Next cycle: owner's done = 1 and err = 1 together. rdata unchanged, last_owner updated.
  - mem_ready on the same edge as the timeout wins, giving a normal completion.
- Undefined:
  - No counter is built and err is tied 0.
  - ACCESS waits indefinitely for mem_ready.

Test Plan:
- Reset release; m0 read addr 0x100, mem_ready on the first ACCESS cycle with mem_rdata 0xDEADBEEF → m0_gnt at cycle 1, mem_en high cycle 1, m0_done at cycle 2, rdata = 0xDEADBEEF.
- m0 and m1 both hold req continuously for 8 accesses, zero-wait memory → grant order m0, m1, m0, m1, ...; one done every 2 cycles; no gnt to a master whose req is low.
- m1 write addr 0x20 data 0x12345678, mem_ready delayed 3 cycles, m1 changes m1_addr after gnt → mem_addr = 0x20 and mem_wdata constant for 4 ACCESS cycles; m1_done once; rdata unchanged.
- Reset asserted in the 2nd ACCESS cycle of an m0 read → all outputs 0 immediately; no m0_done; after release the first tie goes to m0.
- m0 req pulsed for one cycle while m1 holds the bus → m0 gets no access; after m1_done the bus stays IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT = 4, mem_ready never asserted → mem_en high exactly 4 cycles; then m0_done and err pulse together; a subsequent m1 request is served normally.
